key_event_debouncer: RTL and testbench



---
 rtl/key_event_pkg.sv | 28 ++
 rtl/key_event_channel.sv | 133 +++++++++++++
 rtl/key_event_debouncer.sv | 53 +++++
 tb/tb_key_event_debouncer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared types and width helpers for the key event debouncer
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } key_state_e;

    // One-cycle event pulses of a single channel. At most one bit is set per cycle.
    typedef struct packed {
        logic press_evt;
        logic release_evt;
        logic long_evt;
        logic repeat_evt;
    } key_evt_t;

    // Bits needed to hold the values 0..x. Never returns less than 1 so that a
    // degenerate parameter still yields a legal vector.
    function automatic int cnt_w(input int x);
        return (x < 1) ? 1 : $clog2(x + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_channel.sv
// rtl/key_event_channel.sv - single key: synchroniser, debouncer, press/hold FSM and hold counter
//
// Ports:
//   i_clk   - clock
//   i_rst   - synchronous reset, active high
//   i_key   - raw asynchronous key pin
//   o_level - debounced key state, 1 = pressed
//   o_evt   - registered one-cycle event pulses (press, release, long, repeat)
module key_event_channel
    import key_event_pkg::*;
#(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_key,
    output logic     o_level,
    output key_evt_t o_evt
);

    localparam int DB_W   = cnt_w(DEBOUNCE_CYC);
    localparam int HOLD_W = cnt_w(max_int(LONG_CYC, REPEAT_CYC));

    localparam logic [DB_W-1:0]   DB_TERM     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_TERM   = HOLD_W'(LONG_CYC - 1);
    // With repeat disabled the terminal value is never used.
    localparam logic [HOLD_W-1:0] REPEAT_TERM = HOLD_W'((REPEAT_CYC > 0) ? (REPEAT_CYC - 1) : 0);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    key_state_e        state_q, state_d;
    key_evt_t          evt_q, evt_d;

    logic              level_rise;
    logic              level_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            state_q    <= IDLE;
            evt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
            evt_q      <= evt_d;
        end
    end

    // Synchroniser and debouncer. The counter only runs while the synchronised
    // level disagrees with the accepted level; any agreement restarts it.
    always_comb begin
        sync1_d  = i_key ^ ACTIVE_LOW;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_TERM) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        level_rise = level_d & ~level_q;
        level_fall = ~level_d & level_q;
    end

    // Press/hold FSM. Events are decided from the level about to be registered
    // so the press pulse lines up with the first cycle of o_level high.
    // A release is checked before the hold terminal so it always wins a tie.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        evt_d      = '0;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (level_rise) begin
                    state_d         = PRESSED;
                    evt_d.press_evt = 1'b1;
                end
            end
            PRESSED: begin
                if (level_fall) begin
                    state_d           = IDLE;
                    hold_cnt_d        = '0;
                    evt_d.release_evt = 1'b1;
                end else if (hold_cnt_q == LONG_TERM) begin
                    state_d        = HELD;
                    hold_cnt_d     = '0;
                    evt_d.long_evt = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (level_fall) begin
                    state_d           = IDLE;
                    hold_cnt_d        = '0;
                    evt_d.release_evt = 1'b1;
                end else if (REPEAT_CYC > 0) begin
                    if (hold_cnt_q == REPEAT_TERM) begin
                        hold_cnt_d       = '0;
                        evt_d.repeat_evt = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign o_level = level_q;
    assign o_evt   = evt_q;

endmodule

// File: rtl/key_event_debouncer.sv
// rtl/key_event_debouncer.sv - N independent debounced key channels with press/release/long/repeat events
//
// Ports:
//   i_clk     - clock
//   i_rst     - synchronous reset, active high
//   i_key     - raw asynchronous key pins, one per channel
//   o_level   - debounced state per channel, 1 = pressed
//   o_press   - one-cycle pulse on an accepted press
//   o_release - one-cycle pulse on an accepted release
//   o_long    - one-cycle pulse once per hold, LONG_CYC after the press
//   o_repeat  - one-cycle pulse every REPEAT_CYC while held after o_long
module key_event_debouncer
    import key_event_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_key,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat
);

    key_evt_t evt [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        key_event_channel #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_key   (i_key[g]),
            .o_level (o_level[g]),
            .o_evt   (evt[g])
        );

        assign o_press[g]   = evt[g].press_evt;
        assign o_release[g] = evt[g].release_evt;
        assign o_long[g]    = evt[g].long_evt;
        assign o_repeat[g]  = evt[g].repeat_evt;
    end

endmodule

// File: tb/tb_key_event_debouncer.sv
// tb/tb_key_event_debouncer.sv - table-driven self-checking bench for key_event_debouncer
module tb_key_event_debouncer;

    localparam int N_CH = 4;
    localparam int MAXV = 512;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    typedef struct {
        logic [3:0] key;
        logic       rst;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rls;
        logic [3:0] lng;
        logic [3:0] rpt;
    } vec_t;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [N_CH-1:0] i_key = 4'hF;
    logic [N_CH-1:0] o_level, o_press, o_release, o_long, o_repeat;

    vec_t tbl [MAXV];
    int   n_vec = 0;
    int   n_applied = 0;
    int   n_miss = 0;

    always #5 i_clk = ~i_clk;

    key_event_debouncer #(
        .N_CH         (N_CH),
        .ACTIVE_LOW   (1'b1),
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (10),
        .REPEAT_CYC   (3)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_key     (i_key),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long),
        .o_repeat  (o_repeat)
    );

    // Append n cycles of the given inputs with all expectations zero.
    task automatic seg(input logic [3:0] k, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            tbl[n_vec].key = k;
            tbl[n_vec].rst = r;
            tbl[n_vec].lvl = '0;
            tbl[n_vec].prs = '0;
            tbl[n_vec].rls = '0;
            tbl[n_vec].lng = '0;
            tbl[n_vec].rpt = '0;
            n_vec++;
        end
    endtask

    task automatic mark(input int idx, input int kind, input int ch);
        case (kind)
            K_PRESS:   tbl[idx].prs[ch] = 1'b1;
            K_RELEASE: tbl[idx].rls[ch] = 1'b1;
            K_LONG:    tbl[idx].lng[ch] = 1'b1;
            default:   tbl[idx].rpt[ch] = 1'b1;
        endcase
    endtask

    // Expected o_level high on vector indices first..last inclusive.
    task automatic lvl(input int ch, input int first, input int last);
        for (int i = first; i <= last; i++) tbl[i].lvl[ch] = 1'b1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_applied++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // A key applied at vector index s is first sampled at the edge of that
    // vector; press shows in the outputs checked after vector s+5.
    initial begin
        int s, p, cnt;
        bit seen;

        // Reset state.
        seg(4'hF, 1'b1, 2);
        seg(4'hF, 1'b0, 2);

        // 1: clean press and release on ch0, too short for a long press.
        s = n_vec; p = s + 5;
        seg(4'hE, 1'b0, 8);
        seg(4'hF, 1'b0, 10);
        mark(p, K_PRESS, 0);
        lvl(0, p, s + 12);
        mark(s + 13, K_RELEASE, 0);

        // 2: ch1 bounces with 3-cycle pulses, never accepted.
        for (int i = 0; i < 10; i++) begin
            seg(4'hD, 1'b0, 3);
            seg(4'hF, 1'b0, 3);
        end
        seg(4'hF, 1'b0, 4);

        // 3: ch2 held 40 cycles; the 10th repeat slot coincides with the release.
        s = n_vec; p = s + 5;
        seg(4'hB, 1'b0, 40);
        seg(4'hF, 1'b0, 10);
        mark(p, K_PRESS, 2);
        mark(p + 10, K_LONG, 2);
        for (int k = 1; k <= 9; k++) mark(p + 10 + 3 * k, K_REPEAT, 2);
        lvl(2, p, s + 44);
        mark(s + 45, K_RELEASE, 2);

        // 4: ch0 release accepted exactly at p+10.
        s = n_vec; p = s + 5;
        seg(4'hE, 1'b0, 10);
        seg(4'hF, 1'b0, 10);
        mark(p, K_PRESS, 0);
        lvl(0, p, p + 9);
        mark(p + 10, K_RELEASE, 0);

        // 5: all keys together, ch3 released early.
        s = n_vec; p = s + 5;
        seg(4'h0, 1'b0, 6);
        seg(4'h8, 1'b0, 3);
        seg(4'hF, 1'b0, 10);
        for (int c = 0; c < 4; c++) mark(p, K_PRESS, c);
        lvl(3, p, s + 10);
        mark(s + 11, K_RELEASE, 3);
        for (int c = 0; c < 3; c++) begin
            lvl(c, p, s + 13);
            mark(s + 14, K_RELEASE, c);
        end

        // 6: reset while ch0 is HELD, key kept down.
        s = n_vec; p = s + 5;
        seg(4'hE, 1'b0, 17);
        seg(4'hE, 1'b1, 1);
        seg(4'hE, 1'b0, 12);
        seg(4'hF, 1'b0, 12);
        mark(p, K_PRESS, 0);
        mark(p + 10, K_LONG, 0);
        lvl(0, p, s + 16);
        p = s + 23;
        mark(p, K_PRESS, 0);
        mark(p + 10, K_LONG, 0);
        lvl(0, p, s + 34);
        mark(s + 35, K_RELEASE, 0);

        for (int i = 0; i < n_vec; i++) begin
            i_key = tbl[i].key;
            i_rst = tbl[i].rst;
            tick();
            n_applied++;
            if ({o_level, o_press, o_release, o_long, o_repeat} !==
                {tbl[i].lvl, tbl[i].prs, tbl[i].rls, tbl[i].lng, tbl[i].rpt}) begin
                n_miss++;
                $display("FAIL vec %0d: lvl/prs/rls/lng/rpt got %b %b %b %b %b expected %b %b %b %b %b",
                         i, o_level, o_press, o_release, o_long, o_repeat,
                         tbl[i].lvl, tbl[i].prs, tbl[i].rls, tbl[i].lng, tbl[i].rpt);
            end
        end

        // Hand-written: press latency on ch1 measured with a bounded wait.
        i_key = 4'hD;
        cnt = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            cnt++;
            if (o_press[1]) seen = 1;
        end
        check_int("press_latency", seen ? cnt : -1, 6);
        tick();
        check_int("press_width", int'(o_press[1]), 0);
        check_int("level_held", int'(o_level[1]), 1);

        // Release latency on ch1, symmetric to press.
        i_key = 4'hF;
        cnt = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            cnt++;
            if (o_release[1]) seen = 1;
        end
        check_int("release_latency", seen ? cnt : -1, 6);
        check_int("level_after_release", int'(o_level[1]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
